phase_tx: RTL and testbench

Transmit-side counterpart of the CDR receive path. It accepts payload bytes over a valid/ready handshake and prepends an alternating preamble so the receiver's CDR can lock. It serialises the frame LSB-first onto a single phase bit, holding each bit for OSR sample strobes. A companion `o_flag` sample strobe marks every sample, matching the flag/phase pair the receiver consumes.

---
 rtl/phase_tx.sv | 132 +++++++++++++
 tb/tb_phase_tx.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/phase_tx.sv
// phase_tx: transmit-side serialiser for the CDR link.
// Accepts payload bytes over valid/ready, sends an alternating preamble,
// then the bytes LSB-first on o_phase, each bit held for OSR sample strobes
// of DIV clock cycles. A one-bit low tail closes every frame.
module phase_tx #(
  parameter int OSR      = 5,
  parameter int DIV      = 4,
  parameter int PRE_BITS = 8
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [7:0] i_data,
  input  logic       i_valid,
  input  logic       i_last,
  output logic       o_ready,
  output logic       o_phase,
  output logic       o_flag,
  output logic       o_busy,
  output logic       o_underrun
);

  localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int SMP_W = (OSR > 1) ? $clog2(OSR) : 1;
  localparam int BIT_N = (PRE_BITS > 8) ? PRE_BITS : 8;
  localparam int BIT_W = $clog2(BIT_N);

  typedef enum logic [1:0] {IDLE, PREAMBLE, DATA, TAIL} state_t;

  state_t           state, state_nxt;
  logic [DIV_W-1:0] div_cnt;
  logic [SMP_W-1:0] smp_cnt;
  logic [BIT_W-1:0] bit_cnt;

  logic [7:0] buf_data;
  logic       buf_last;
  logic       buf_full;
  logic [7:0] sh;
  logic       sh_last;
  logic       phase;

  logic strobe, boundary, pre_end, byte_end, reload, drain, accept;

  // Timing events derived from the counters; the frame boundaries fall on
  // the last strobe of a bit.
  assign strobe   = (state != IDLE) && (div_cnt == DIV_W'(DIV - 1));
  assign boundary = strobe && (smp_cnt == SMP_W'(OSR - 1));
  assign pre_end  = (state == PREAMBLE) && boundary && (bit_cnt == BIT_W'(PRE_BITS - 1));
  assign byte_end = (state == DATA) && boundary && (bit_cnt == BIT_W'(7));
  assign reload   = byte_end && !sh_last && buf_full;
  // The buffer drains only while full and accepts only while empty, so a
  // drain and an accept can never land in the same cycle.
  assign drain    = pre_end || reload;
  assign accept   = i_valid && !buf_full;

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_rst) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:     if (buf_full) state_nxt = PREAMBLE;
      PREAMBLE: if (pre_end) state_nxt = DATA;
      DATA:     if (byte_end && !reload) state_nxt = TAIL;
      TAIL:     if (boundary) state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  // Outputs decoded from state and counters.
  always_comb begin
    o_ready    = !buf_full;
    o_busy     = (state != IDLE);
    o_flag     = strobe;
    o_underrun = byte_end && !sh_last && !buf_full;
    o_phase    = phase;
  end

  // Clock divider, sample counter and bit counter; all parked at 0 in IDLE.
  always_ff @(posedge i_clk) begin
    if (i_rst || state == IDLE) begin
      div_cnt <= '0;
      smp_cnt <= '0;
      bit_cnt <= '0;
    end else begin
      div_cnt <= strobe ? '0 : div_cnt + 1'b1;
      if (strobe) smp_cnt <= (smp_cnt == SMP_W'(OSR - 1)) ? '0 : smp_cnt + 1'b1;
      if (boundary) begin
        if (pre_end || byte_end || state == TAIL) bit_cnt <= '0;
        else                                      bit_cnt <= bit_cnt + 1'b1;
      end
    end
  end

  // One-byte holding buffer between the handshake and the shifter.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      buf_full <= 1'b0;
      buf_last <= 1'b0;
    end else if (drain) begin
      buf_full <= 1'b0;
    end else if (accept) begin
      buf_full <= 1'b1;
      buf_last <= i_last;
    end
    if (accept) buf_data <= i_data;
  end

  // Shifter and registered phase bit; phase only changes after a bit
  // boundary, so it is stable across all OSR strobes of a bit.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      sh_last <= 1'b0;
      phase   <= 1'b0;
    end else begin
      unique case (state)
        IDLE:     phase <= buf_full;
        PREAMBLE: if (boundary) phase <= pre_end ? buf_data[0] : bit_cnt[0];
        DATA:     if (boundary) phase <= byte_end ? (reload & buf_data[0]) : sh[1];
        TAIL:     phase <= 1'b0;
        default:  phase <= 1'b0;
      endcase
      if (drain) sh_last <= buf_last;
    end
    if (drain)                                 sh <= buf_data;
    else if (state == DATA && boundary)        sh <= sh >> 1;
  end

endmodule

// File: tb/tb_phase_tx.sv
// tb_phase_tx: scoreboard bench for phase_tx. Stimulus queues the expected
// bit stream and per-frame totals; a negedge monitor rebuilds bits from the
// o_flag strobes and compares against the queues.
module tb_phase_tx;

  localparam int OSR      = 5;
  localparam int DIV      = 4;
  localparam int PRE_BITS = 8;

  typedef struct {
    int busy_cyc;
    int flags;
    int unds;
  } frame_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] data = 8'h00;
  logic       valid = 1'b0;
  logic       last = 1'b0;
  logic       ready, phase, flag, busy, underrun;

  int errors = 0;
  int checks = 0;

  bit     exp_bits[$];
  frame_t exp_frames[$];

  phase_tx #(.OSR(OSR), .DIV(DIV), .PRE_BITS(PRE_BITS)) dut (
    .i_clk     (clk),
    .i_rst     (rst),
    .i_data    (data),
    .i_valid   (valid),
    .i_last    (last),
    .o_ready   (ready),
    .o_phase   (phase),
    .o_flag    (flag),
    .o_busy    (busy),
    .o_underrun(underrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Monitor: reconstructs bits and frame totals from the DUT outputs.
  int smp_i = 0;
  bit bit_val = 1'b0;
  bit bit_stable = 1'b1;
  int busy_cnt = 0, flag_cnt = 0, und_cnt = 0;
  bit prev_busy = 1'b0, prev_ready = 1'b1, prev_accept = 1'b0, prev_boundary = 1'b0;

  always @(negedge clk) begin
    if (rst) begin
      smp_i = 0; busy_cnt = 0; flag_cnt = 0; und_cnt = 0;
      prev_busy = 1'b0; prev_ready = 1'b1; prev_accept = 1'b0; prev_boundary = 1'b0;
    end else begin
      if (prev_accept) check("ready_drop_after_accept", int'(ready), 0);
      if (ready && !prev_ready) check("ready_rise_after_drain", int'(prev_boundary), 1);
      prev_boundary = 1'b0;
      if (busy) busy_cnt++;
      if (underrun) begin
        und_cnt++;
        check("underrun_on_last_strobe", int'(flag && smp_i == OSR - 1), 1);
      end
      if (flag) begin
        flag_cnt++;
        if (smp_i == 0) begin
          bit_val = phase;
          bit_stable = 1'b1;
        end else if (phase !== bit_val) begin
          bit_stable = 1'b0;
        end
        if (smp_i == OSR - 1) begin
          smp_i = 0;
          prev_boundary = 1'b1;
          if (exp_bits.size() == 0) begin
            checks++; errors++;
            $display("FAIL bit_unexpected: got bit %0d, expected none (t=%0t)", bit_val, $time);
          end else begin
            bit e;
            e = exp_bits.pop_front();
            check("bit_value", int'(bit_val), int'(e));
            check("bit_stable", int'(bit_stable), 1);
          end
        end else begin
          smp_i++;
        end
      end
      if (prev_busy && !busy) begin
        if (exp_frames.size() == 0) begin
          checks++; errors++;
          $display("FAIL frame_unexpected: got busy=%0d cycles, expected no frame", busy_cnt);
        end else begin
          frame_t f;
          f = exp_frames.pop_front();
          check("frame_busy_cycles", busy_cnt, f.busy_cyc);
          check("frame_flag_pulses", flag_cnt, f.flags);
          check("frame_underruns", und_cnt, f.unds);
          check("frame_bits_left", exp_bits.size(), 0);
        end
        busy_cnt = 0; flag_cnt = 0; und_cnt = 0; smp_i = 0;
      end
      prev_busy   = busy;
      prev_ready  = ready;
      prev_accept = valid && ready;
    end
  end

  // Push the expected bit stream and hand-computed frame totals.
  task automatic queue_frame(input logic [7:0] b[4], input int n,
                             input int busy_cyc, input int flags, input int unds);
    frame_t f;
    for (int i = 0; i < PRE_BITS; i++) exp_bits.push_back((i % 2) == 0);
    for (int k = 0; k < n; k++)
      for (int j = 0; j < 8; j++) exp_bits.push_back(b[k][j]);
    exp_bits.push_back(1'b0);
    f.busy_cyc = busy_cyc; f.flags = flags; f.unds = unds;
    exp_frames.push_back(f);
  endtask

  // Offer one byte; called just after a rising edge, returns just after the accept edge.
  task automatic send_byte(input logic [7:0] d, input logic l, input bit hold);
    int n;
    n = 0;
    data = d; last = l; valid = 1'b1;
    @(negedge clk);
    while (!ready && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check("send_ready_wait", int'(ready), 1);
    @(posedge clk); #1;
    if (!hold) valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((exp_frames.size() != 0 || busy) && n < 5000) begin
      @(posedge clk);
      n++;
    end
    check("frame_completed", exp_frames.size(), 0);
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ready"}, int'(ready), 1);
    check({tag, "_busy"}, int'(busy), 0);
    check({tag, "_phase"}, int'(phase), 0);
    check({tag, "_flag"}, int'(flag), 0);
    check({tag, "_underrun"}, int'(underrun), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no completion, expected finish before 1ms");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] b[4];

    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_reset_outputs("reset");
    @(posedge clk); #1;

    // Single byte 0xA5, last.
    b = '{8'hA5, 8'h00, 8'h00, 8'h00};
    queue_frame(b, 1, 340, 85, 0);
    send_byte(8'hA5, 1'b1, 1'b0);
    wait_idle();

    // Back-to-back 0x00 then 0xFF (last).
    b = '{8'h00, 8'hFF, 8'h00, 8'h00};
    queue_frame(b, 2, 500, 125, 0);
    send_byte(8'h00, 1'b0, 1'b0);
    send_byte(8'hFF, 1'b1, 1'b0);
    wait_idle();

    // Underrun: 0x3C without last and nothing after it.
    b = '{8'h3C, 8'h00, 8'h00, 8'h00};
    queue_frame(b, 1, 340, 85, 1);
    send_byte(8'h3C, 1'b0, 1'b0);
    wait_idle();

    // Backpressure: valid held high across a four-byte stream.
    b = '{8'h5A, 8'h96, 8'h01, 8'h80};
    queue_frame(b, 4, 820, 205, 0);
    send_byte(8'h5A, 1'b0, 1'b1);
    send_byte(8'h96, 1'b0, 1'b1);
    send_byte(8'h01, 1'b0, 1'b1);
    send_byte(8'h80, 1'b1, 1'b0);
    wait_idle();

    // Mid-frame reset during data bit 3, then a fresh frame.
    b = '{8'hC3, 8'h00, 8'h00, 8'h00};
    queue_frame(b, 1, 340, 85, 0);
    send_byte(8'hC3, 1'b1, 1'b0);
    repeat (2 + (PRE_BITS + 3) * OSR * DIV + 7) @(posedge clk);
    #1;
    check("midreset_busy_before", int'(busy), 1);
    rst = 1'b1;
    exp_bits.delete();
    exp_frames.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check_reset_outputs("midreset");
    @(posedge clk); #1;
    b = '{8'h96, 8'h00, 8'h00, 8'h00};
    queue_frame(b, 1, 340, 85, 0);
    send_byte(8'h96, 1'b1, 1'b0);
    wait_idle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
